// File: rtl/hm_rx.sv
// hm_rx: checks PCIe completion TLPs and realigns the payload into 64-bit dword pairs. Optional HM_RX_STRICT_CHECK_EN adds a requester ID/tag check.
// Latency: one cycle from the accepted beat to rx_data. A trailing half-word appears one cycle after the eof-beat output.
// Backpressure: none. trn_rdst_rdy_n is held low from the first cycle after reset, so the sink is always ready.
module hm_rx #(
    parameter logic [7:0] HM_RX_TAG = 8'h38
) (
    input  logic        trn_clk,
    input  logic        trn_reset_n,
    input  logic [63:0] trn_rd,
    input  logic        trn_rsof_n,
    input  logic        trn_reof_n,
    input  logic        trn_rrem_n,
    input  logic        trn_rsrc_rdy_n,
    input  logic        trn_rsrc_dsc_n,
    output logic        trn_rdst_rdy_n,
    input  logic [7:0]  cfg_bus_number,
    input  logic [4:0]  cfg_device_number,
    input  logic [2:0]  cfg_function_number,
    output logic [63:0] rx_data,
    output logic        rx_data_we,
    output logic        rx_data_half,
    output logic        rx_end,
    output logic        rx_err,
    output logic [31:0] stat_trn_cpt_rx,
    output logic [31:0] stat_trn_cpt_drop,
    output logic [1:0]  stat_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        rdy_n_q;
    logic [31:0] carry_q, carry_d;
    logic        last_q, last_d, nodata_q, nodata_d;
    logic        pend_q, pend_d, pend_end_q, pend_end_d;
    logic [63:0] data_q, data_d;
    logic        we_q, we_d, half_q, half_d, end_q, end_d, err_q, err_d;
    logic [31:0] cpt_rx_q, cpt_rx_d, drop_q, drop_d;

    logic        beat, sof, eof, dsc;
    logic        is_cpld, is_cpl, hdr_valid, cpl_last, hdr_ok;
    logic [12:0] len_bytes, bc_bytes;

    assign beat = !trn_rsrc_rdy_n && !rdy_n_q;
    assign sof  = beat && !trn_rsof_n;
    assign eof  = beat && !trn_reof_n;
    assign dsc  = !trn_rsrc_dsc_n && !rdy_n_q;

    assign is_cpld   = (trn_rd[63:56] == {3'b010, 5'b01010});
    assign is_cpl    = (trn_rd[63:56] == {3'b000, 5'b01010});
    assign hdr_valid = is_cpld || is_cpl;
    // Zero-valued length and byte count fields encode their maximum.
    assign len_bytes = {trn_rd[41:32] == 10'd0, trn_rd[41:32], 2'b00};
    assign bc_bytes  = {trn_rd[11:0] == 12'd0, trn_rd[11:0]};
    assign cpl_last  = (bc_bytes <= len_bytes);

`ifdef HM_RX_STRICT_CHECK_EN
    assign hdr_ok = (trn_rd[63:48] == {cfg_bus_number, cfg_device_number, cfg_function_number})
                 && (trn_rd[47:40] == HM_RX_TAG);
`else
    logic unused_cfg;
    assign hdr_ok     = 1'b1;
    assign unused_cfg = ^{cfg_bus_number, cfg_device_number, cfg_function_number, HM_RX_TAG};
`endif

    always_ff @(posedge trn_clk) begin
        if (!trn_reset_n) state_q <= S_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (dsc) begin
            state_d = S_IDLE;
        end else if (beat) begin
            case (state_q)
                S_IDLE: if (sof) state_d = (!hdr_valid || eof) ? (eof ? S_IDLE : S_DROP) : S_HDR;
                S_HDR:  state_d = eof ? S_IDLE : (hdr_ok ? S_DATA : S_DROP);
                default: if (eof) state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        data_d     = data_q;
        we_d       = 1'b0;
        half_d     = 1'b0;
        end_d      = 1'b0;
        err_d      = 1'b0;
        carry_d    = carry_q;
        last_d     = last_q;
        nodata_d   = nodata_q;
        pend_d     = 1'b0;
        pend_end_d = 1'b0;
        cpt_rx_d   = cpt_rx_q;
        drop_d     = drop_q;
        if (pend_q && !dsc) begin
            data_d = {carry_q, 32'h0};
            we_d   = 1'b1;
            half_d = 1'b1;
            end_d  = pend_end_q;
        end
        // A TLP already sitting in DROP was counted when it was rejected.
        if (dsc) begin
            if (state_q == S_HDR || state_q == S_DATA || (state_q == S_IDLE && sof))
                drop_d = drop_q + 32'd1;
        end else if (beat) begin
            case (state_q)
                S_IDLE: if (sof) begin
                    last_d   = cpl_last;
                    nodata_d = is_cpl || (trn_rd[15:13] != 3'b000);
                    if (!hdr_valid || eof) drop_d = drop_q + 32'd1;
                end
                S_HDR: begin
                    if (!hdr_ok) begin
                        drop_d = drop_q + 32'd1;
                    end else begin
                        carry_d = trn_rd[31:0];
                        if (eof) begin
                            cpt_rx_d = cpt_rx_q + 32'd1;
                            end_d    = nodata_q || last_q;
                            err_d    = nodata_q;
                            if (!nodata_q) begin
                                data_d = {trn_rd[31:0], 32'h0};
                                we_d   = 1'b1;
                                half_d = 1'b1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (!nodata_q) begin
                        data_d  = {carry_q, trn_rd[63:32]};
                        we_d    = 1'b1;
                        carry_d = trn_rd[31:0];
                    end
                    if (eof) begin
                        cpt_rx_d = cpt_rx_q + 32'd1;
                        if (nodata_q) begin
                            end_d = 1'b1;
                            err_d = 1'b1;
                        end else if (trn_rrem_n) begin
                            pend_d     = 1'b1;
                            pend_end_d = last_q;
                        end else begin
                            end_d = last_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge trn_clk) begin
        if (!trn_reset_n) begin
            rdy_n_q    <= 1'b1;
            carry_q    <= 32'h0;
            last_q     <= 1'b0;
            nodata_q   <= 1'b0;
            pend_q     <= 1'b0;
            pend_end_q <= 1'b0;
            data_q     <= 64'h0;
            we_q       <= 1'b0;
            half_q     <= 1'b0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;
            cpt_rx_q   <= 32'h0;
            drop_q     <= 32'h0;
        end else begin
            rdy_n_q    <= 1'b0;
            carry_q    <= carry_d;
            last_q     <= last_d;
            nodata_q   <= nodata_d;
            pend_q     <= pend_d;
            pend_end_q <= pend_end_d;
            data_q     <= data_d;
            we_q       <= we_d;
            half_q     <= half_d;
            end_q      <= end_d;
            err_q      <= err_d;
            cpt_rx_q   <= cpt_rx_d;
            drop_q     <= drop_d;
        end
    end

    assign trn_rdst_rdy_n    = rdy_n_q;
    assign rx_data           = data_q;
    assign rx_data_we        = we_q;
    assign rx_data_half      = half_q;
    assign rx_end            = end_q;
    assign rx_err            = err_q;
    assign stat_trn_cpt_rx   = cpt_rx_q;
    assign stat_trn_cpt_drop = drop_q;
    assign stat_state        = state_q;
endmodule
